// File: rtl/rope_position_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rope_position_ctrl
//  Description : Tug-of-war rope position owner. Accumulates move pulses into
//                a clamped target position and animates the displayed rope
//                position toward it one pixel per animation tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module rope_position_ctrl #(
    parameter int CENTER_X = 320,
    parameter int STEP_PX  = 40,
    parameter int MIN_X    = 80,
    parameter int MAX_X    = 560,
    parameter int TICK_DIV = 500000
) (
    input  logic       clk_100mhz,
    input  logic       reset,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       game_over,
    output logic [9:0] rope_pos_x,
    output logic [9:0] target_x,
    output logic       moving,
    output logic       arrived
);

    localparam int                   c_CNT_W     = $clog2(TICK_DIV);
    localparam logic [c_CNT_W-1:0]   c_TICK_LAST = c_CNT_W'(TICK_DIV - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [9:0]           c_CENTER    = 10'(CENTER_X);
    localparam logic [9:0]           c_MIN       = 10'(MIN_X);
    localparam logic [9:0]           c_MAX       = 10'(MAX_X);
    // Signed arithmetic carries guard bits so the target never wraps at 0/1023
    localparam logic signed [11:0]   c_STEP_S    = 12'(STEP_PX);
    localparam logic signed [11:0]   c_MIN_S     = 12'(MIN_X);
    localparam logic signed [11:0]   c_MAX_S     = 12'(MAX_X);

    logic [c_CNT_W-1:0] r_tick_cnt;
    logic [9:0]         r_rope_pos_x;
    logic [9:0]         r_target_x;
    logic               r_moving;
    logic               r_arrived;

    logic               w_tick;
    logic signed [11:0] w_dec;
    logic signed [11:0] w_inc;
    logic [9:0]         w_target_next;
    logic [9:0]         w_rope_next;
    logic               w_step;

    assign w_tick = (r_tick_cnt == c_TICK_LAST);
    assign w_dec  = $signed({2'b00, r_target_x}) - c_STEP_S;
    assign w_inc  = $signed({2'b00, r_target_x}) + c_STEP_S;

    // Next target/position: game over snaps the target to the frozen rope,
    // opposing pulses cancel, and the rope steps toward the current target.
    always_comb begin
        w_target_next = r_target_x;
        w_rope_next   = r_rope_pos_x;
        w_step        = 1'b0;

        if (game_over) begin
            w_target_next = r_rope_pos_x;
        end else if (move_left && !move_right) begin
            w_target_next = (w_dec < c_MIN_S) ? c_MIN : w_dec[9:0];
        end else if (move_right && !move_left) begin
            w_target_next = (w_inc > c_MAX_S) ? c_MAX : w_inc[9:0];
        end

        if (w_tick && !game_over) begin
            if (r_rope_pos_x < r_target_x) begin
                w_rope_next = r_rope_pos_x + 10'd1;
                w_step      = 1'b1;
            end else if (r_rope_pos_x > r_target_x) begin
                w_rope_next = r_rope_pos_x - 10'd1;
                w_step      = 1'b1;
            end
        end
    end

    // Free-running animation tick divider, independent of game_over
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_CNT_ONE;
        end
    end

    // Position/target registers and status flags derived from next-state values
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            r_rope_pos_x <= c_CENTER;
            r_target_x   <= c_CENTER;
            r_moving     <= 1'b0;
            r_arrived    <= 1'b0;
        end else begin
            r_rope_pos_x <= w_rope_next;
            r_target_x   <= w_target_next;
            r_moving     <= (w_rope_next != w_target_next);
            r_arrived    <= w_step && (w_rope_next == w_target_next);
        end
    end

    assign rope_pos_x = r_rope_pos_x;
    assign target_x   = r_target_x;
    assign moving     = r_moving;
    assign arrived    = r_arrived;

endmodule
`default_nettype wire

// File: tb/tb_rope_position_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rope_position_ctrl
//  Description : Directed self-checking bench for rope_position_ctrl with a
//                per-cycle expected-value scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rope_position_ctrl;

    localparam int c_CX   = 320;
    localparam int c_STEP = 40;
    localparam int c_MINX = 80;
    localparam int c_MAXX = 560;
    localparam int c_TD   = 4;

    logic       clk_100mhz = 1'b0;
    logic       reset      = 1'b1;
    logic       move_left  = 1'b0;
    logic       move_right = 1'b0;
    logic       game_over  = 1'b0;
    logic [9:0] rope_pos_x;
    logic [9:0] target_x;
    logic       moving;
    logic       arrived;

    rope_position_ctrl #(
        .CENTER_X (c_CX),
        .STEP_PX  (c_STEP),
        .MIN_X    (c_MINX),
        .MAX_X    (c_MAXX),
        .TICK_DIV (c_TD)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .move_left  (move_left),
        .move_right (move_right),
        .game_over  (game_over),
        .rope_pos_x (rope_pos_x),
        .target_x   (target_x),
        .moving     (moving),
        .arrived    (arrived)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    typedef struct packed {
        logic [9:0] pos;
        logic [9:0] tgt;
        logic       mov;
        logic       arr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_pos = 0;
    int   m_tgt = 0;
    int   m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Predict the next registered outputs from the driven inputs, queue them,
    // clock once, then pop and compare against the DUT.
    task automatic cycle();
        exp_t e;
        exp_t got_exp;
        int   npos;
        int   ntgt;
        bit   tick;
        e = '0;
        if (reset) begin
            npos  = c_CX;
            ntgt  = c_CX;
            m_cnt = 0;
            e.arr = 1'b0;
        end else begin
            tick  = (m_cnt == c_TD - 1);
            m_cnt = tick ? 0 : m_cnt + 1;
            ntgt  = m_tgt;
            if (game_over)
                ntgt = m_pos;
            else if (move_left && !move_right)
                ntgt = (m_tgt - c_STEP < c_MINX) ? c_MINX : m_tgt - c_STEP;
            else if (move_right && !move_left)
                ntgt = (m_tgt + c_STEP > c_MAXX) ? c_MAXX : m_tgt + c_STEP;
            npos = m_pos;
            if (tick && !game_over) begin
                if (m_pos < m_tgt) npos = m_pos + 1;
                else if (m_pos > m_tgt) npos = m_pos - 1;
            end
            e.arr = (npos != m_pos) && (npos == ntgt);
        end
        e.pos = 10'(npos);
        e.tgt = 10'(ntgt);
        e.mov = (npos != ntgt);
        sb.push_back(e);
        m_pos = npos;
        m_tgt = ntgt;
        @(posedge clk_100mhz);
        #1;
        got_exp = sb.pop_front();
        chk("sb_pos", 32'(rope_pos_x), 32'(got_exp.pos));
        chk("sb_tgt", 32'(target_x),   32'(got_exp.tgt));
        chk("sb_mov", 32'(moving),     32'(got_exp.mov));
        chk("sb_arr", 32'(arrived),    32'(got_exp.arr));
    endtask

    task automatic run_until(input int pos, input int bound, output int arrs);
        int n;
        n    = 0;
        arrs = 0;
        while (rope_pos_x !== 10'(pos) && n < bound) begin
            cycle();
            n++;
            if (arrived === 1'b1) arrs++;
        end
        chk("reach_pos_timeout", 32'(rope_pos_x), 32'(pos));
    endtask

    task automatic pulse_left();
        move_left = 1'b1;
        cycle();
        move_left = 1'b0;
    endtask

    task automatic pulse_right();
        move_right = 1'b1;
        cycle();
        move_right = 1'b0;
    endtask

    initial begin
        int arrs;

        // Reset state
        reset = 1'b1;
        cycle();
        cycle();
        chk("rst_pos", 32'(rope_pos_x), 32'd320);
        chk("rst_tgt", 32'(target_x),   32'd320);
        chk("rst_mov", 32'(moving),     32'd0);
        chk("rst_arr", 32'(arrived),    32'd0);
        reset = 1'b0;
        cycle();

        // Opposing pulses cancel
        move_left  = 1'b1;
        move_right = 1'b1;
        cycle();
        move_left  = 1'b0;
        move_right = 1'b0;
        chk("both_tgt", 32'(target_x), 32'd320);
        chk("both_mov", 32'(moving),   32'd0);

        // Single left move animates down to 280 with exactly one arrival
        pulse_left();
        chk("left_tgt", 32'(target_x), 32'd280);
        chk("left_mov", 32'(moving),   32'd1);
        run_until(280, 200, arrs);
        chk("left_arr_cnt", 32'(arrs),   32'd1);
        chk("left_mov_end", 32'(moving), 32'd0);
        repeat (8) cycle();
        chk("left_hold", 32'(rope_pos_x), 32'd280);

        // Right moves 10 cycles apart, clamping at MAX_X
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            pulse_right();
            chk("right_tgt", 32'(target_x), 32'((i < 6) ? 360 + 40 * i : 560));
            repeat (9) cycle();
        end
        run_until(540, 1000, arrs);

        // Game over freezes at 540 and ignores moves
        game_over = 1'b1;
        cycle();
        chk("go_pos", 32'(rope_pos_x), 32'd540);
        chk("go_tgt", 32'(target_x),   32'd540);
        chk("go_mov", 32'(moving),     32'd0);
        pulse_right();
        repeat (4) cycle();
        pulse_left();
        repeat (4) cycle();
        chk("go_ign_tgt", 32'(target_x),   32'd540);
        chk("go_ign_pos", 32'(rope_pos_x), 32'd540);
        game_over = 1'b0;
        repeat (12) cycle();
        chk("go_rel_pos", 32'(rope_pos_x), 32'd540);
        chk("go_rel_mov", 32'(moving),     32'd0);

        // Low clamp: freeze at 100 to make target 100, then one left -> 80
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (6) pulse_left();
        chk("low_tgt6", 32'(target_x), 32'd80);
        run_until(100, 1000, arrs);
        game_over = 1'b1;
        cycle();
        game_over = 1'b0;
        chk("low_frz_tgt", 32'(target_x), 32'd100);
        pulse_left();
        chk("low_clamp_tgt", 32'(target_x), 32'd80);
        pulse_left();
        chk("low_clamp2_tgt", 32'(target_x), 32'd80);
        run_until(80, 200, arrs);
        chk("low_arr_cnt", 32'(arrs), 32'd1);

        // Reset mid-animation, then tick counter restarts from zero
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        pulse_right();
        run_until(350, 400, arrs);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("mid_rst_pos", 32'(rope_pos_x), 32'd320);
        chk("mid_rst_tgt", 32'(target_x),   32'd320);
        chk("mid_rst_mov", 32'(moving),     32'd0);
        chk("mid_rst_arr", 32'(arrived),    32'd0);
        pulse_left();
        chk("restart_e1", 32'(rope_pos_x), 32'd320);
        cycle();
        chk("restart_e2", 32'(rope_pos_x), 32'd320);
        cycle();
        chk("restart_e3", 32'(rope_pos_x), 32'd320);
        cycle();
        chk("restart_e4", 32'(rope_pos_x), 32'd319);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
